// File: rtl/register_pkg.sv
// Shared constants for the generic datapath storage register.
package register_pkg;
    localparam int unsigned DEFAULT_WIDTH = 12;
endpackage

// File: rtl/register.sv
// Write-enabled flop bank.
// Asynchronous active-high clear; when wrEn is high it captures dataIn on the rising clock edge.
module register
    import register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrEn,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
);

    // Reset wins over a coincident write. dataOut comes straight from the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut <= '0;
        end else if (wrEn) begin
            dataOut <= dataIn;
        end
    end

`ifndef SYNTHESIS
    a_reset_clears : assert property (@(posedge clk) rst |=> dataOut == '0);

    a_hold : assert property (@(posedge clk) disable iff (rst)
        (!wrEn) |=> dataOut == $past(dataOut));

    a_capture : assert property (@(posedge clk) disable iff (rst)
        wrEn |=> dataOut == $past(dataIn));

    a_no_x : assert property (@(posedge clk) !rst |-> !$isunknown(dataOut));
`endif

endmodule

// File: tb/tb_register.sv
// Directed and randomised checks of the write-enabled register at WIDTH = 12.
module tb_register;
    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         wrEn;
    logic [W-1:0] dataIn;
    logic [W-1:0] dataOut;

    int n_cmp = 0;
    int n_err = 0;

    register #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrEn),
        .dataIn (dataIn),
        .dataOut(dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] exp);
        n_cmp++;
        if (dataOut !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, dataOut, exp, $time);
        end
    endtask

    task automatic write_cycle(input logic en, input logic [W-1:0] d);
        @(negedge clk);
        wrEn   = en;
        dataIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        wrEn   = 1'b0;
        dataIn = 'x;
        #2 rst = 1'b1;
        #1 check("reset_async", 12'h000);
        @(posedge clk);
        #1 check("reset_through_edge", 12'h000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hold_after_reset();
        write_cycle(1'b0, 12'd20);
        check("hold_after_reset", 12'h000);
    endtask

    task automatic test_write_hold();
        write_cycle(1'b1, 12'd43);
        check("write_43", 12'd43);
        write_cycle(1'b0, 12'd7);
        check("hold_43", 12'd43);
        write_cycle(1'b0, 12'd7);
        check("hold_43_again", 12'd43);
    endtask

    task automatic test_back_to_back();
        write_cycle(1'b1, 12'hFFF);
        check("b2b_fff", 12'hFFF);
        write_cycle(1'b1, 12'h000);
        check("b2b_000", 12'h000);
        write_cycle(1'b1, 12'h5A5);
        check("b2b_5a5", 12'h5A5);
        write_cycle(1'b1, 12'hA5A);
        check("b2b_a5a", 12'hA5A);
    endtask

    task automatic test_async_reset();
        write_cycle(1'b1, 12'd43);
        check("pre_reset_43", 12'd43);
        @(negedge clk);
        wrEn   = 1'b1;
        dataIn = 12'd99;
        #2 rst = 1'b1;
        #1 check("mid_cycle_clear", 12'h000);
        @(posedge clk);
        #1 check("write_blocked_by_reset", 12'h000);
        @(negedge clk);
        rst  = 1'b0;
        wrEn = 1'b0;
        write_cycle(1'b1, 12'h123);
        check("first_write_after_reset", 12'h123);
    endtask

    task automatic test_random();
        logic [W-1:0] exp;
        logic         prev_rst;
        exp      = dataOut;
        prev_rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 9) == 0);
            wrEn   = $urandom_range(0, 1);
            dataIn = W'($urandom_range(0, (1 << W) - 1));
            if (rst && !prev_rst) begin
                exp = '0;
                #1 check("random_async_clear", exp);
            end
            prev_rst = rst;
            @(posedge clk);
            if (rst) exp = '0;
            else if (wrEn) exp = dataIn;
            #1 check("random_edge", exp);
        end
        @(negedge clk);
        rst  = 1'b0;
        wrEn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold_after_reset();
        test_write_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
